// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop synchroniser, start-bit qualification, 3-vote mid-cell
// sampling, 5..9 data bits, optional parity, 1/2 stop bits, valid/ready output with error flags.
module uart_rx_os #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SW  = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] TMAX    = TW'(DIV - 1);
  localparam logic [SW-1:0] SVOTE0  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SVOTE1  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] SRESOLV = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] SLAST   = SW'(OVERSAMPLE - 1);
  localparam logic [3:0]    DMAX    = 4'(DATA_BITS - 1);
  localparam logic [3:0]    SBMAX   = 4'(STOP_BITS - 1);

  if (DIV < 1 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_err
    $error("uart_rx_os: illegal parameter combination");
  end

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e               state_q;
  logic                 rx_meta_q, rx_s;
  logic [TW-1:0]        tcnt_q;
  logic [SW-1:0]        scnt_q;
  logic [1:0]           vote_q;
  logic [3:0]           bit_idx_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 par_q;
  logic                 stop_ok_q;
  logic                 armed_q;

  logic tick, resolve, wrap, bit_val, stop_ok_now, par_x, par_err, last_stop;

  always_comb begin
    tick        = (tcnt_q == TMAX);
    resolve     = tick && (scnt_q == SRESOLV);
    wrap        = tick && (scnt_q == SLAST);
    bit_val     = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);
    stop_ok_now = stop_ok_q & bit_val;
    par_x       = (^shreg_q) ^ par_q;
    par_err     = (PARITY == 1) ? ~par_x : (PARITY == 2) ? par_x : 1'b0;
    last_stop   = (bit_idx_q == SBMAX);
  end

  // Synchroniser and tick/sample counters; counters sit at zero in IDLE so phase follows the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
      tcnt_q    <= '0;
      scnt_q    <= '0;
    end else begin
      rx_meta_q <= rx;
      rx_s      <= rx_meta_q;
      if (state_q == StIdle) begin
        tcnt_q <= '0;
        scnt_q <= '0;
      end else begin
        tcnt_q <= tick ? '0 : tcnt_q + TW'(1);
        if (tick) scnt_q <= (scnt_q == SLAST) ? '0 : scnt_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      busy       <= 1'b0;
      vote_q     <= 2'b11;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      stop_ok_q  <= 1'b1;
      armed_q    <= 1'b1;
      data       <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (valid && ready) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
      if (tick && scnt_q == SVOTE0) vote_q[0] <= rx_s;
      if (tick && scnt_q == SVOTE1) vote_q[1] <= rx_s;

      unique case (state_q)
        StIdle: begin
          bit_idx_q <= '0;
          // After a frame the line must be seen high once, so a break yields a single word.
          if (rx_s) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            state_q <= StStart;
            busy    <= 1'b1;
          end
        end
        StStart: begin
          if (resolve && bit_val) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else if (wrap) begin
            state_q <= StData;
          end
        end
        StData: begin
          if (resolve) shreg_q <= {bit_val, shreg_q[DATA_BITS-1:1]};
          if (wrap) begin
            if (bit_idx_q == DMAX) begin
              bit_idx_q <= '0;
              stop_ok_q <= 1'b1;
              state_q   <= (PARITY != 0) ? StParity : StStop;
            end else begin
              bit_idx_q <= bit_idx_q + 4'd1;
            end
          end
        end
        StParity: begin
          if (resolve) par_q <= bit_val;
          if (wrap) state_q <= StStop;
        end
        StStop: begin
          if (resolve) begin
            stop_ok_q <= stop_ok_now;
            // Complete at mid-cell of the last stop bit so an early next start edge is caught.
            if (last_stop) begin
              state_q <= StIdle;
              busy    <= 1'b0;
              armed_q <= 1'b0;
              if (!valid || ready) begin
                data       <= shreg_q;
                frame_err  <= ~stop_ok_now;
                parity_err <= par_err;
                valid      <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end else if (wrap) begin
            bit_idx_q <= bit_idx_q + 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised, oversampling UART receiver that replaces the fixed-rate receiver in the serial path. It synchronises the asynchronous `rx` line, detects and qualifies start bits, and majority-votes each bit at mid-cell. It supports 5–9 data bits, optional parity and 1 or 2 stop bits, and delivers each word over a valid/ready handshake with framing, parity and overrun flags. It sits between the board pin and the byte consumer (command parser / FIFO).

## Interface
- `CLK_FREQ`, 50_000_000: clock frequency in Hz.
- `BAUD`, 115200: line rate in bit/s.
- `OVERSAMPLE`, 16: ticks per bit cell. Must be even and ≥ 8.
- `DATA_BITS`, 8: data width, 5..9.
- `PARITY`, 0: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1: 1 or 2.
- `clk` input 1: single clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `rx` input 1: asynchronous serial line, idle high.
- `data` output DATA_BITS: received word, LSB = first data bit on the line.
- `valid` output 1: `data` and the error flags hold a word.
- `ready` input 1: consumer accepts the word when `valid && ready`.
- `frame_err` output 1: a stop bit of the current word sampled 0.
- `parity_err` output 1: parity mismatch for the current word; always 0 when PARITY=0.
- `overrun` output 1: sticky; a completed frame was dropped.
- `busy` output 1: receiver is not in IDLE.

## Operation
- **Synchroniser:** 2-flop, both flops reset to 1. All logic uses the second flop (`rx_s`).
- **Tick generator:**
  - DIV = CLK_FREQ / (BAUD*OVERSAMPLE), integer truncation; elaboration error if DIV < 1.
  - Counter runs 0..DIV-1 and is free-running outside IDLE.
  - The counter is cleared on start-edge detection, so tick phase is aligned to the edge.
  - One-cycle `tick` pulse when count == DIV-1.
- **Sample counter:** `scnt`, 0..OVERSAMPLE-1, advances on `tick`.
  - Votes are taken at scnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - Bit value = majority of the 3 votes; it is resolved at the tick where scnt = OVERSAMPLE/2+1.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: `rx_s` == 0 → START. Clears tick and `scnt` counters, bit index = 0.
  - START: if the resolved bit is 1, treat as a false start and go to IDLE; nothing is output. If 0, continue counting. At scnt wrap (OVERSAMPLE-1 → 0), go to DATA.
  - DATA: resolved bit is shifted in LSB-first. After the DATA_BITS-th wrap, go to PARITY if PARITY≠0, else to STOP.
  - PARITY: resolved bit is captured. Mismatch rule: odd requires the XOR of data and parity bit = 1; even requires it = 0. Go to STOP at wrap.
  - STOP: each stop bit's resolved value is ANDed into `stop_ok`.
    - On the resolution tick of the last stop bit: complete the frame, go to IDLE.
    - The FSM does not wait for the end of the stop cell, so a start edge in the second half of the stop bit is caught.
- **Frame completion:**
  - If `valid` == 0, or `valid && ready` in the same cycle: load `data`, `frame_err` = !stop_ok, `parity_err`, and set `valid` = 1.
  - Otherwise drop the new frame, set `overrun` = 1, and keep the old word and its flags unchanged.
- **Handshake:**
  - `valid` stays high until `valid && ready`; it clears the next cycle unless a completion coincides.
  - `data` and flags are stable while `valid` is high.
  - `overrun` clears on the next `valid && ready` transfer.
- **Break** (rx held low): delivers `data` = 0 with `frame_err` = 1. The FSM then waits in IDLE until `rx_s` returns high before re-arming.
  - Required IDLE entry condition: `rx_s` must be seen high once after STOP before another start is accepted.

## Timing
- **Reset values:** `data` = 0, `valid` = 0, `frame_err` = 0, `parity_err` = 0, `overrun` = 0, `busy` = 0. FSM = IDLE, synchroniser = 1.
- **Reset mid-frame:** abort with no output, and the FSM is in IDLE the cycle after reset deasserts.
- **Input latency:** 2 clocks from the `rx` pin to `rx_s`.
- **Output latency:** `valid` rises 1 clock after the last stop bit's resolution tick.
- **`busy`:**
  - Rises 1 clock after `rx_s` falls.
  - Falls with the FSM's return to IDLE, i.e. in the same cycle as the `valid` update.
- **Throughput:** back-to-back frames with 1 stop bit at nominal baud are received without loss when `ready` is held high.
- **Baud tolerance:** sampling error stays within ±1 tick per bit. The receiver tolerates ±2% baud error with 10-bit frames.

## Test plan
All scenarios use CLK_FREQ=1_600_000, BAUD=10_000, OVERSAMPLE=16 (DIV=10, 160 clk/bit).

- **8N1, `ready` = 1:** send 0xA5 → `valid` pulses 1 clk carrying `data` = 0xA5, `frame_err` = 0, `parity_err` = 0. `valid` rises 1 clk after the stop-bit resolution tick.
- **Glitch:** 3-clk-wide low glitch on idle `rx` → START aborts, no `valid`, `busy` returns to 0 within 160 clk.
- **8E1 parity:** send 0x03 with parity bit 1 → `data` = 0x03, `parity_err` = 1. Then send 0x03 with parity bit 0 → `parity_err` = 0.
- **Frame error and break:**
  - Send 0x55 with stop bit 0 → `data` = 0x55, `frame_err` = 1.
  - Hold `rx` low for 2000 clk → single word `data` = 0x00, `frame_err` = 1, no further words until `rx` goes high.
- **Overrun:** `ready` = 0; send 0x11 then 0x22 → `data` stays 0x11, `overrun` = 1. Then assert `ready` 1 clk → `valid` = 0 and `overrun` = 0 the next cycle.
- **Reset mid-frame:** assert `reset` 1 clk mid-DATA while sending 0xFF → all outputs 0, no `valid`. A following clean 0x3C is received correctly.
